// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage hazard controller.
// Produces stalls, bubbles and flushes for IF/ID/EX from three sources:
// load-use dependencies, the multi-cycle MULT/DIV unit (MDU) and MEM exceptions.
// The outputs are combinational from the controller state and the current inputs.
module id_hazard_ctrl #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_reg_s,
  input  logic [4:0]       id_reg_t,
  input  logic             id_use_s,
  input  logic             id_use_t,
  input  logic             id_mdu_start,
  input  logic             id_mdu_read,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_reg_d,
  input  logic             mem_exc_req,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             flush_all,
  output logic             mdu_start_ok,
  output logic             mdu_busy
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MDU_BUSY  = 2'd1,
    EXC_FLUSH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic load_use;
  logic mdu_haz;
  logic hazard_stall;
  logic start_ok;

  // A load in EX whose destination is read by the ID instruction; r0 never creates a dependency.
  assign load_use = id_valid & ex_mem_read & (ex_reg_d != 5'd0) &
                    ((id_use_s & (id_reg_s == ex_reg_d)) |
                     (id_use_t & (id_reg_t == ex_reg_d)));

  // Any MDU access from ID must wait while the unit is still computing HI/LO.
  assign mdu_haz = id_valid & (state == MDU_BUSY) & (id_mdu_start | id_mdu_read);

  // Only a plain RUN cycle with no load-use and no exception may launch a new MULT/DIV.
  assign start_ok = (state == RUN) & id_valid & id_mdu_start & ~load_use & ~mem_exc_req;

  // Stalls apply outside the flush cycle and are overridden by an exception.
  assign hazard_stall = ~mem_exc_req & (state != EXC_FLUSH) & (mdu_haz | load_use);

  // Next-state and MDU countdown; an exception aborts any MDU operation in flight.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (mem_exc_req) begin
      state_nxt = EXC_FLUSH;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RUN: begin
          if (start_ok) begin
            state_nxt = MDU_BUSY;
            cnt_nxt   = CNT_W'(MDU_LATENCY);
          end
        end
        MDU_BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        EXC_FLUSH: begin
          state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and counter registers with asynchronous return to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output decode; everything is held low while reset is asserted.
  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    bubble_ex    = 1'b0;
    flush_if_id  = 1'b0;
    flush_all    = 1'b0;
    mdu_start_ok = 1'b0;
    mdu_busy     = 1'b0;
    if (!rst) begin
      stall_if     = hazard_stall;
      stall_id     = hazard_stall;
      bubble_ex    = hazard_stall;
      flush_if_id  = (state == EXC_FLUSH);
      flush_all    = mem_exc_req;
      mdu_start_ok = start_ok;
      mdu_busy     = (state == MDU_BUSY);
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: self-checking bench for id_hazard_ctrl.
// Combinational decode is checked from a vector table, multi-cycle behaviour from
// hand-written sequences, and random traffic against a cycle-level reference model.
module tb_id_hazard_ctrl;

  localparam int LAT = 4;

  typedef struct packed {
    logic       v;
    logic [4:0] s;
    logic [4:0] t;
    logic       us;
    logic       ut;
    logic       start;
    logic       rd;
    logic       exr;
    logic [4:0] d;
    logic       exc;
  } in_t;

  typedef struct packed {
    in_t        stim;
    logic [6:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid, id_use_s, id_use_t, id_mdu_start, id_mdu_read;
  logic [4:0] id_reg_s, id_reg_t, ex_reg_d;
  logic       ex_mem_read, mem_exc_req;
  logic       stall_if, stall_id, bubble_ex, flush_if_id, flush_all, mdu_start_ok, mdu_busy;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: remaining busy cycles and whether a wrong-path flush is owed.
  int busy_left     = 0;
  bit flush_pending = 0;

  id_hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_reg_s(id_reg_s), .id_reg_t(id_reg_t),
    .id_use_s(id_use_s), .id_use_t(id_use_t),
    .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read),
    .ex_mem_read(ex_mem_read), .ex_reg_d(ex_reg_d), .mem_exc_req(mem_exc_req),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .flush_all(flush_all),
    .mdu_start_ok(mdu_start_ok), .mdu_busy(mdu_busy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic in_t mkIn(input logic v, input logic [4:0] s, input logic [4:0] t,
                               input logic us, input logic ut, input logic start,
                               input logic rd, input logic exr, input logic [4:0] d,
                               input logic exc);
    in_t x;
    x.v = v; x.s = s; x.t = t; x.us = us; x.ut = ut;
    x.start = start; x.rd = rd; x.exr = exr; x.d = d; x.exc = exc;
    return x;
  endfunction

  function automatic in_t randIn();
    in_t x;
    x.v     = ($urandom_range(0, 7) != 0);
    x.s     = 5'($urandom_range(0, 3));
    x.t     = 5'($urandom_range(0, 3));
    x.us    = 1'($urandom_range(0, 1));
    x.ut    = 1'($urandom_range(0, 1));
    x.start = ($urandom_range(0, 7) == 0);
    x.rd    = ($urandom_range(0, 5) == 0);
    x.exr   = 1'($urandom_range(0, 1));
    x.d     = 5'($urandom_range(0, 3));
    x.exc   = ($urandom_range(0, 19) == 0);
    return x;
  endfunction

  function automatic logic modelLoadUse(input in_t x);
    return x.v && x.exr && (x.d != 5'd0) &&
           ((x.us && (x.s == x.d)) || (x.ut && (x.t == x.d)));
  endfunction

  // Expected {stall_if, stall_id, bubble_ex, flush_if_id, flush_all, mdu_start_ok, mdu_busy}.
  function automatic logic [6:0] modelOut(input in_t x);
    logic [6:0] r;
    logic       lu;
    logic       st;
    r  = '0;
    lu = modelLoadUse(x);
    if (rst) return r;
    r[0] = (busy_left > 0);
    r[3] = flush_pending;
    if (x.exc) begin
      r[2] = 1'b1;
    end else if (!flush_pending) begin
      if (busy_left > 0) st = lu || (x.v && (x.start || x.rd));
      else               st = lu;
      r[6:4] = {3{st}};
      r[1]   = (busy_left == 0) && x.v && x.start && !lu;
    end
    return r;
  endfunction

  task automatic modelEdge(input in_t x);
    if (x.exc) begin
      flush_pending = 1'b1;
      busy_left     = 0;
    end else if (flush_pending) begin
      flush_pending = 1'b0;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
    end else if (x.v && x.start && !modelLoadUse(x)) begin
      busy_left = LAT;
    end
  endtask

  task automatic applyStimulus(input in_t x);
    id_valid     = x.v;
    id_reg_s     = x.s;
    id_reg_t     = x.t;
    id_use_s     = x.us;
    id_use_t     = x.ut;
    id_mdu_start = x.start;
    id_mdu_read  = x.rd;
    ex_mem_read  = x.exr;
    ex_reg_d     = x.d;
    mem_exc_req  = x.exc;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {stall_if, stall_id, bubble_ex, flush_if_id, flush_all, mdu_start_ok, mdu_busy};
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // One clock cycle checked against the reference model.
  task automatic modelCycle(input string name, input in_t x);
    @(negedge clk);
    applyStimulus(x);
    #1;
    checkOutput(name, modelOut(x));
    modelEdge(x);
  endtask

  // One clock cycle checked against a hand-derived constant.
  task automatic handCycle(input string name, input in_t x, input logic [6:0] exp);
    @(negedge clk);
    applyStimulus(x);
    #1;
    checkOutput(name, exp);
    modelEdge(x);
  endtask

  in_t  idle, mult, mfhi, excx;
  vec_t vecs[12];

  initial begin
    idle = mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mult = mkIn(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    mfhi = mkIn(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    excx = mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    vecs[0]  = '{mkIn(1, 5, 0, 1, 0, 0, 0, 1, 5, 0), 7'b1110000};
    vecs[1]  = '{mkIn(1, 0, 0, 1, 0, 0, 0, 1, 0, 0), 7'b0000000};
    vecs[2]  = '{mkIn(0, 5, 0, 1, 0, 0, 0, 1, 5, 0), 7'b0000000};
    vecs[3]  = '{mkIn(1, 1, 7, 0, 1, 0, 0, 1, 7, 0), 7'b1110000};
    vecs[4]  = '{mkIn(1, 7, 7, 0, 0, 0, 0, 1, 7, 0), 7'b0000000};
    vecs[5]  = '{mkIn(1, 5, 5, 1, 1, 0, 0, 0, 5, 0), 7'b0000000};
    vecs[6]  = '{mkIn(1, 5, 0, 1, 0, 0, 0, 1, 5, 1), 7'b0000100};
    vecs[7]  = '{mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 7'b0000100};
    vecs[8]  = '{mkIn(1, 2, 3, 1, 1, 1, 0, 1, 9, 0), 7'b0000010};
    vecs[9]  = '{mkIn(1, 2, 3, 1, 1, 1, 0, 1, 3, 0), 7'b1110000};
    vecs[10] = '{mkIn(1, 0, 0, 0, 0, 1, 0, 0, 0, 1), 7'b0000100};
    vecs[11] = '{mkIn(1, 0, 0, 0, 0, 0, 1, 0, 0, 0), 7'b0000000};

    // Reset holds every output low even with an exception and a load-use present.
    applyStimulus(mkIn(1, 5, 0, 1, 0, 1, 0, 1, 5, 1));
    #2;
    checkOutput("reset outputs", 7'b0000000);
    applyStimulus(idle);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelCycle("after reset idle", idle);

    // Decode table in RUN; inputs return to idle before the edge so state is untouched.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].stim);
      #1;
      checkOutput($sformatf("vector %0d", i), vecs[i].exp);
      #1;
      applyStimulus(idle);
    end

    // MULT accepted, busy for LAT cycles, MFHI stalled until the first RUN cycle.
    handCycle("T2 accept", mult, 7'b0000010);
    handCycle("T2 busy c1", idle, 7'b0000001);
    for (int c = 2; c <= 4; c++) handCycle($sformatf("T2 mfhi stall c%0d", c), mfhi, 7'b1110001);
    handCycle("T2 mfhi release", mfhi, 7'b0000000);

    // Exception during MDU_BUSY aborts the operation and owes one IF/ID flush.
    handCycle("T3 accept", mult, 7'b0000010);
    handCycle("T3 busy", idle, 7'b0000001);
    handCycle("T3 exception", mkIn(1, 0, 0, 0, 0, 0, 1, 0, 0, 1), 7'b0000101);
    handCycle("T3 flush_if_id", idle, 7'b0001000);
    handCycle("T3 run", mfhi, 7'b0000000);

    // Repeated exceptions keep the controller in the flush state.
    handCycle("exc twice a", excx, 7'b0000100);
    handCycle("exc twice b", excx, 7'b0001100);
    handCycle("exc twice c", idle, 7'b0001000);

    // Back-to-back DIVs: the second waits, then is accepted in the first RUN cycle.
    handCycle("T5 accept 1", mult, 7'b0000010);
    for (int c = 1; c <= 4; c++) handCycle($sformatf("T5 div stall c%0d", c), mult, 7'b1110001);
    handCycle("T5 accept 2", mult, 7'b0000010);
    for (int c = 1; c <= 4; c++) handCycle($sformatf("T5 busy2 c%0d", c), idle, 7'b0000001);
    handCycle("T5 done", idle, 7'b0000000);

    // Reset pulsed between edges while busy drops everything immediately.
    handCycle("T6 accept", mult, 7'b0000010);
    handCycle("T6 busy", mfhi, 7'b1110001);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("T6 reset mid-busy", 7'b0000000);
    #1;
    rst = 1'b0;
    busy_left     = 0;
    flush_pending = 1'b0;
    handCycle("T6 run after reset", mfhi, 7'b0000000);
    handCycle("T6 new accept", mult, 7'b0000010);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) modelCycle("random", randIn());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
